// File: rtl/mem_arbiter.sv
// mem_arbiter: two-way arbiter that shares one single-word backing-memory
// port between an I-cache refill requester and a D-cache refill/writeback
// requester. Each grant moves a whole BEATS-word cache-line burst.
//
// Configuration macro: MEM_ARB_DPRIO_EN
//   undefined : simultaneous requests in IDLE are granted round-robin
//   defined   : simultaneous requests in IDLE always go to the D side
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   i_req      I-cache line refill request
//   i_addr     I-cache line address (word/beat offset bits ignored)
//   i_rdata    I-cache refill word, valid while i_rvalid=1
//   i_rvalid   I-cache refill word strobe
//   i_done     I-cache burst-complete strobe
//   d_req      D-cache request
//   d_we       D-cache direction: 1 writeback, 0 refill
//   d_addr     D-cache line address (word/beat offset bits ignored)
//   d_wdata    current D-cache writeback word
//   d_wready   writeback word accepted this cycle
//   d_rdata    D-cache refill word, valid while d_rvalid=1
//   d_rvalid   D-cache refill word strobe
//   d_done     D-cache burst-complete strobe
//   mem_req    backing-memory word request
//   mem_we     backing-memory write enable
//   mem_addr   backing-memory byte address
//   mem_wdata  backing-memory write data
//   mem_ack    backing-memory accept/complete for the current word
//   mem_rdata  backing-memory read data, valid with mem_ack

module mem_arbiter #(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int BW  = $clog2(BEATS);
  localparam int LSB = BW + 2;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [31:LSB]   base_q, base_d;
  logic            we_q, we_d;
  logic            owner_d_q, owner_d_d;
  logic [31:0]     i_rdata_q, i_rdata_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic            grant_d;
`ifndef MEM_ARB_DPRIO_EN
  logic            last_i_q, last_i_d;
`endif

  // Offset bits of the request addresses are replaced by the beat counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LSB-1:0], d_addr[LSB-1:0]};

  // D wins a tie when fixed priority is built in, otherwise only when I
  // held the port last; the reset value of the flag lets D win the first tie.
  always_comb begin
`ifdef MEM_ARB_DPRIO_EN
    grant_d = d_req;
`else
    grant_d = d_req && (!i_req || last_i_q);
`endif
  end

  // State register plus all datapath flops; reset abandons any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      owner_d_q  <= 1'b0;
      i_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
`ifndef MEM_ARB_DPRIO_EN
      last_i_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      we_q       <= we_d;
      owner_d_q  <= owner_d_d;
      i_rdata_q  <= i_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_rvalid_q <= d_rvalid_d;
`ifndef MEM_ARB_DPRIO_EN
      last_i_q   <= last_i_d;
`endif
    end
  end

  // Next-state logic: the owner's address and direction are frozen at the
  // grant edge so later requester changes cannot disturb the burst.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    we_d      = we_q;
    owner_d_d = owner_d_q;
`ifndef MEM_ARB_DPRIO_EN
    last_i_d  = last_i_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = GNT_D;
          base_d    = d_addr[31:LSB];
          we_d      = d_we;
          owner_d_d = 1'b1;
          beat_d    = '0;
`ifndef MEM_ARB_DPRIO_EN
          last_i_d  = 1'b0;
`endif
        end else if (i_req) begin
          state_d   = GNT_I;
          base_d    = i_addr[31:LSB];
          we_d      = 1'b0;
          owner_d_d = 1'b0;
          beat_d    = '0;
`ifndef MEM_ARB_DPRIO_EN
          last_i_d  = 1'b1;
`endif
        end
      end
      GNT_I, GNT_D: begin
        // The counter width is exactly log2(BEATS), so the increment after
        // the final beat wraps it back to zero.
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-data capture: the owning side sees its word one cycle after the ack.
  always_comb begin
    i_rvalid_d = (state_q == GNT_I) && mem_ack;
    d_rvalid_d = (state_q == GNT_D) && !we_q && mem_ack;
    i_rdata_d  = i_rvalid_d ? mem_rdata : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
  end

  // Output logic.
  always_comb begin
    mem_req   = (state_q == GNT_I) || (state_q == GNT_D);
    mem_we    = (state_q == GNT_D) && we_q;
    mem_addr  = mem_req ? {base_q, beat_q, 2'b00} : 32'h0;
    mem_wdata = d_wdata;
    d_wready  = (state_q == GNT_D) && we_q && mem_ack;
    i_done    = (state_q == DONE) && !owner_d_q;
    d_done    = (state_q == DONE) && owner_d_q;
    i_rdata   = i_rdata_q;
    i_rvalid  = i_rvalid_q;
    d_rdata   = d_rdata_q;
    d_rvalid  = d_rvalid_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A transaction-level model
// predicts the order of bursts from the arbitration rules and queues every
// expected memory beat; a monitor pops and checks each accepted beat and the
// read-data / done strobes that follow it.

module tb_mem_arbiter;
  localparam int BEATS = 4;
  localparam int LINE  = BEATS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_rvalid, i_done;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_wready;
  logic [31:0] d_rdata;
  logic        d_rvalid, d_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          owner_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          last;
  } beat_t;

  beat_t       sb_q[$];
  int          total = 0;
  int          bad = 0;
  bit          exp_rv_i = 0, exp_rv_d = 0, exp_done_i = 0, exp_done_d = 0;
  logic [31:0] exp_rdata = '0;
  bit          model_last_i = 1;
  logic [31:0] d_words [BEATS];
  int          d_idx = 0;
  bit          abort = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a line burst is BEATS consecutive words from the aligned line base.
  task automatic push_burst(input bit owner_d, input bit we, input logic [31:0] addr);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.owner_d = owner_d;
      e.we      = we;
      e.addr    = (addr & ~32'(LINE - 1)) + 32'(b * 4);
      e.wdata   = we ? d_words[b] : 32'h0;
      e.last    = (b == BEATS - 1);
      sb_q.push_back(e);
    end
  endtask

  // One requester cycle: sample strobes mid-cycle, react just after the edge.
  task automatic run_cycle();
    bit sw, sd, si;
    @(negedge clk);
    sw = d_wready; sd = d_done; si = i_done;
    @(posedge clk);
    #1;
    if (sw && d_idx < BEATS - 1) d_idx++;
    d_wdata = d_words[d_idx];
    if (sd) d_req = 1'b0;
    if (si) i_req = 1'b0;
  endtask

  // Raise one or both requests together from idle, predict the grant order,
  // and run until both requesters have seen their done strobe.
  task automatic applyStimulus(input bit want_i, input bit want_d, input bit we,
                               input logic [31:0] ia, input logic [31:0] da);
    bit winner_d;
    int cyc;
    if (abort) return;
    for (int b = 0; b < BEATS; b++) d_words[b] = $urandom;
    if (want_i && want_d) begin
`ifdef MEM_ARB_DPRIO_EN
      winner_d = 1'b1;
`else
      winner_d = model_last_i;
`endif
    end else begin
      winner_d = want_d;
    end
    if (winner_d) push_burst(1'b1, we, da); else push_burst(1'b0, 1'b0, ia);
    if (want_i && want_d) begin
      if (winner_d) push_burst(1'b0, 1'b0, ia); else push_burst(1'b1, we, da);
      model_last_i = winner_d;
    end else begin
      model_last_i = !winner_d;
    end
    i_addr = ia; d_addr = da; d_we = we;
    d_idx = 0; d_wdata = d_words[0];
    i_req = want_i; d_req = want_d;
    cyc = 0;
    while ((i_req || d_req) && cyc < 300) begin
      run_cycle();
      cyc++;
      // The winner was granted on the first edge; its inputs are now don't-care.
      if (winner_d && d_req) begin
        if (!want_i || !i_req) begin d_addr = $urandom; d_we = $urandom_range(0, 1); end
        else d_addr = $urandom;
      end else if (!winner_d && i_req) begin
        i_addr = $urandom;
      end
    end
    if (i_req || d_req) begin
      checkOutput("round_timeout", {30'h0, i_req, d_req}, 32'h0);
      abort = 1;
    end
  endtask

  // Backing memory: random acks (including spurious ones when idle).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
    end
  end

  // Monitor: checks strobes owed from the previous cycle, then any new beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_rv_i || i_rvalid) begin
          checkOutput("i_rvalid", i_rvalid, exp_rv_i);
          if (exp_rv_i) checkOutput("i_rdata", i_rdata, exp_rdata);
        end
        if (exp_rv_d || d_rvalid) begin
          checkOutput("d_rvalid", d_rvalid, exp_rv_d);
          if (exp_rv_d) checkOutput("d_rdata", d_rdata, exp_rdata);
        end
        if (exp_done_i || i_done) checkOutput("i_done", i_done, exp_done_i);
        if (exp_done_d || d_done) checkOutput("d_done", d_done, exp_done_d);
        exp_rv_i = 0; exp_rv_d = 0; exp_done_i = 0; exp_done_d = 0;
        if (mem_req && mem_ack) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_beat", mem_req, 1'b0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("mem_addr", mem_addr, e.addr);
            checkOutput("mem_we", mem_we, e.we);
            if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
            checkOutput("d_wready", d_wready, e.owner_d && e.we);
            if (!e.we) begin
              if (e.owner_d) exp_rv_d = 1; else exp_rv_i = 1;
              exp_rdata = mem_rdata;
            end
            if (e.last) begin
              if (e.owner_d) exp_done_d = 1; else exp_done_i = 1;
            end
          end
        end else if (d_wready) begin
          checkOutput("d_wready_noack", d_wready, 1'b0);
        end
      end
    end
  end

  initial begin
    int cyc;
    for (int b = 0; b < BEATS; b++) d_words[b] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_i_rvalid", i_rvalid, 1'b0);
    checkOutput("rst_d_rvalid", d_rvalid, 1'b0);
    checkOutput("rst_i_done", i_done, 1'b0);
    checkOutput("rst_d_done", d_done, 1'b0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Directed refill and writeback lines, then ties and random traffic.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0040);
    for (int r = 0; r < 6; r++)
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int r = 0; r < 30; r++) begin
      int pick;
      pick = $urandom_range(1, 3);
      applyStimulus(1'(pick & 1), 1'(pick >> 1), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    // Reset in the middle of an I refill with a D request waiting.
    if (!abort) begin
      for (int b = 0; b < BEATS; b++) d_words[b] = $urandom;
      push_burst(1'b0, 1'b0, 32'h0000_2200);
      i_addr = 32'h0000_2200; i_req = 1'b1;
      run_cycle();
      d_we = 1'b1; d_addr = 32'h0000_5560; d_idx = 0; d_wdata = d_words[0]; d_req = 1'b1;
      cyc = 0;
      while (sb_q.size() > BEATS - 2 && cyc < 200) begin
        run_cycle();
        cyc++;
      end
      checkOutput("reached_beat2", sb_q.size(), BEATS - 2);
      #1 rst = 1'b0;
      #1;
      checkOutput("async_mem_req", mem_req, 1'b0);
      checkOutput("async_mem_addr", mem_addr, 32'h0);
      sb_q.delete();
      exp_rv_i = 0; exp_rv_d = 0; exp_done_i = 0; exp_done_d = 0;
      i_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_no_i_done", i_done, 1'b0);
      checkOutput("rst_d_wready", d_wready, 1'b0);
      checkOutput("rst_i_rvalid2", i_rvalid, 1'b0);
      model_last_i = 1;
      push_burst(1'b1, 1'b1, 32'h0000_5560);
      model_last_i = 0;
      d_idx = 0; d_wdata = d_words[0];
      @(posedge clk);
      #2 rst = 1'b1;
      cyc = 0;
      while (d_req && cyc < 300) begin
        run_cycle();
        cyc++;
      end
      if (d_req) checkOutput("post_reset_timeout", d_req, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
